pq_sorted_queue: RTL and testbench

- Shift-register priority queue for quickq_v2: holds up to DEPTH unsigned keys, sorted so the largest key is at the head.
- Every entry has its own unsigned strict greater-than comparison of the incoming key against the stored key.
- Those compare results steer the parallel insert and shift.
- Output is the current maximum key; a downstream consumer pops it with deq.

---
 rtl/pq_sorted_queue.sv | 203 ++++++++++++++++++++
 tb/tb_pq_sorted_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pq_sorted_queue.sv
// pq_sorted_queue
// Shift-register priority queue. Holds up to DEPTH unsigned keys, kept sorted
// so that the largest key is always at index 0 (the head). Each entry compares
// the incoming key against its own stored key. Those compare results steer a
// parallel insert and shift. No priority encoder is needed.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   enq      insert din this cycle
//   deq      remove the head this cycle
//   din      key to insert (W bits, unsigned)
//   dout     head (largest) key; 0 when empty
//   count    number of valid entries
//   empty    count == 0
//   full     count == DEPTH
//   enq_err  one-cycle pulse: enq refused (full, no deq)
//   deq_err  one-cycle pulse: deq refused (empty)
//
// All outputs come from registers only. An operation issued in cycle N becomes
// visible after posedge N+1.

module pq_sorted_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  logic                       deq,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       enq_err,
    output logic                       deq_err
);

    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_INSERT,
        OP_REMOVE,
        OP_REPLACE
    } op_t;

    logic [W-1:0]  r_key [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CW-1:0] r_count;
    logic          r_enq_err;
    logic          r_deq_err;

    logic          w_empty;
    logic          w_full;
    op_t           w_op;
    logic          w_enq_err;
    logic          w_deq_err;

    // Views of neighbouring entries. The "_s" view is the queue after the head
    // has been popped: entry i sees entry i+1, and the last entry sees an
    // invalid slot.
    logic [W-1:0]  w_key_s    [DEPTH];
    logic [DEPTH-1:0] w_valid_s;
    logic [W-1:0]  w_prev_key [DEPTH];
    logic [DEPTH-1:0] w_prev_valid;

    // Per-entry "din belongs at or before this slot" flags. The sort invariant
    // makes these thermometer codes (0..0 1..1). So the insert point is the
    // entry whose flag is set while its predecessor's flag is clear.
    logic [DEPTH-1:0] w_g;
    logic [DEPTH-1:0] w_gs;
    logic [DEPTH-1:0] w_prev_g;
    logic [DEPTH-1:0] w_prev_gs;

    logic [W-1:0]  w_key_nxt [DEPTH];
    logic [DEPTH-1:0] w_valid_nxt;
    logic [CW-1:0] w_count_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (i == DEPTH-1) begin : g_last
            assign w_key_s[i]   = '0;
            assign w_valid_s[i] = 1'b0;
        end else begin : g_body
            assign w_key_s[i]   = r_key[i+1];
            assign w_valid_s[i] = r_valid[i+1];
        end

        // Strict compare: an equal key queues behind the keys already stored.
        assign w_g[i]  = !r_valid[i]   | (din > r_key[i]);
        assign w_gs[i] = !w_valid_s[i] | (din > w_key_s[i]);

        if (i == 0) begin : g_first
            assign w_prev_key[i]   = '0;
            assign w_prev_valid[i] = 1'b0;
            assign w_prev_g[i]     = 1'b0;
            assign w_prev_gs[i]    = 1'b0;
        end else begin : g_rest
            assign w_prev_key[i]   = r_key[i-1];
            assign w_prev_valid[i] = r_valid[i-1];
            assign w_prev_g[i]     = w_g[i-1];
            assign w_prev_gs[i]    = w_gs[i-1];
        end
    end

    // Operation select. enq and deq together on an empty queue is a plain
    // insert, and the deq half of the request is reported as refused.
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // skipped an assignment would infer a latch.
        w_op      = OP_IDLE;
        w_enq_err = 1'b0;
        w_deq_err = 1'b0;
        if (enq && deq) begin
            if (w_empty) begin
                w_op      = OP_INSERT;
                w_deq_err = 1'b1;
            end else begin
                w_op = OP_REPLACE;
            end
        end else if (enq) begin
            if (w_full) w_enq_err = 1'b1;
            else        w_op      = OP_INSERT;
        end else if (deq) begin
            if (w_empty) w_deq_err = 1'b1;
            else         w_op      = OP_REMOVE;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        for (int i = 0; i < DEPTH; i++) begin
            w_key_nxt[i]   = r_key[i];
            w_valid_nxt[i] = r_valid[i];
            unique case (w_op)
                OP_INSERT: begin
                    if (w_prev_g[i]) begin
                        // Behind the insert point: shift down by one.
                        w_key_nxt[i]   = w_prev_key[i];
                        w_valid_nxt[i] = w_prev_valid[i];
                    end else if (w_g[i]) begin
                        w_key_nxt[i]   = din;
                        w_valid_nxt[i] = 1'b1;
                    end
                end
                OP_REMOVE: begin
                    w_key_nxt[i]   = w_key_s[i];
                    w_valid_nxt[i] = w_valid_s[i];
                end
                OP_REPLACE: begin
                    // Pop and insert at once: entries ahead of the new key
                    // shift up, and entries behind it stay where they are.
                    if (!w_gs[i]) begin
                        w_key_nxt[i]   = w_key_s[i];
                        w_valid_nxt[i] = w_valid_s[i];
                    end else if (!w_prev_gs[i]) begin
                        w_key_nxt[i]   = din;
                        w_valid_nxt[i] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        case (w_op)
            OP_INSERT: w_count_nxt = r_count + CW'(1);
            OP_REMOVE: w_count_nxt = r_count - CW'(1);
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the key array is reset along with valid because invalid
            // entries must read 0. This lets dout show 0 when the queue is
            // empty without any extra muxing.
            for (int i = 0; i < DEPTH; i++) r_key[i] <= '0;
            r_valid   <= '0;
            r_count   <= '0;
            r_enq_err <= 1'b0;
            r_deq_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every entry see the same
            // pre-edge neighbours during the parallel shift.
            for (int i = 0; i < DEPTH; i++) r_key[i] <= w_key_nxt[i];
            r_valid   <= w_valid_nxt;
            r_count   <= w_count_nxt;
            r_enq_err <= w_enq_err;
            r_deq_err <= w_deq_err;
        end
    end

    assign dout    = r_key[0];
    assign count   = r_count;
    assign empty   = w_empty;
    assign full    = w_full;
    assign enq_err = r_enq_err;
    assign deq_err = r_deq_err;

endmodule

// File: tb/tb_pq_sorted_queue.sv
// tb_pq_sorted_queue
// Directed bench for pq_sorted_queue with W=8 and DEPTH=4. Each stimulus
// cycle pushes its hand-computed expected outputs into a scoreboard. A monitor
// pops one entry just after each rising edge and compares it against the
// DUT ports.

module tb_pq_sorted_queue;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    typedef struct {
        string    name;
        int       dout;
        int       count;
        int       empty;
        int       full;
        int       enq_err;
        int       deq_err;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          enq;
    logic          deq;
    logic [W-1:0]  din;
    logic [W-1:0]  dout;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          enq_err;
    logic          deq_err;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pq_sorted_queue #(.W(W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .enq     (enq),
        .deq     (deq),
        .din     (din),
        .dout    (dout),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .enq_err (enq_err),
        .deq_err (deq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and push the outputs expected after the
    // next rising edge.
    task automatic step(input string name, input logic r, input logic e,
                        input logic d, input int k, input int x_dout,
                        input int x_count, input int x_empty, input int x_full,
                        input int x_eerr, input int x_derr);
        exp_t x;
        @(negedge clk);
        rst = r;
        enq = e;
        deq = d;
        din = W'(k);
        x.name    = name;
        x.dout    = x_dout;
        x.count   = x_count;
        x.empty   = x_empty;
        x.full    = x_full;
        x.enq_err = x_eerr;
        x.deq_err = x_derr;
        sb.push_back(x);
    endtask

    // Monitor: compares the DUT ports against the scoreboard, away from the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check({x.name, ".dout"},    int'(dout),    x.dout);
                check({x.name, ".count"},   int'(count),   x.count);
                check({x.name, ".empty"},   int'(empty),   x.empty);
                check({x.name, ".full"},    int'(full),    x.full);
                check({x.name, ".enq_err"}, int'(enq_err), x.enq_err);
                check({x.name, ".deq_err"}, int'(deq_err), x.deq_err);
            end
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b1;
        enq = 1'b0;
        deq = 1'b0;
        din = '0;

        //    name          rst enq deq din  dout cnt emp ful eer der
        // 1. Reset, then idle
        step("reset",        1, 0, 0,   0,    0,  0,  1,  0,  0,  0);
        step("idle0",        0, 0, 0,   0,    0,  0,  1,  0,  0,  0);
        // 2. Fill with a tie on 30
        step("enq10",        0, 1, 0,  10,   10,  1,  0,  0,  0,  0);
        step("enq30",        0, 1, 0,  30,   30,  2,  0,  0,  0,  0);
        step("enq20",        0, 1, 0,  20,   30,  3,  0,  0,  0,  0);
        step("enq30b",       0, 1, 0,  30,   30,  4,  0,  1,  0,  0);
        // 3. Refused insert, then replace while full
        step("enq50_full",   0, 1, 0,  50,   30,  4,  0,  1,  1,  0);
        step("eerr_clear",   0, 0, 0,   0,   30,  4,  0,  1,  0,  0);
        step("replace25",    0, 1, 1,  25,   30,  4,  0,  1,  0,  0);
        // 4. Drain [30,25,20,10], then underflow
        step("deq_a",        0, 0, 1,   0,   25,  3,  0,  0,  0,  0);
        step("deq_b",        0, 0, 1,   0,   20,  2,  0,  0,  0,  0);
        step("deq_c",        0, 0, 1,   0,   10,  1,  0,  0,  0,  0);
        step("deq_d",        0, 0, 1,   0,    0,  0,  1,  0,  0,  0);
        step("deq_empty",    0, 0, 1,   0,    0,  0,  1,  0,  0,  1);
        step("derr_clear",   0, 0, 0,   0,    0,  0,  1,  0,  0,  0);
        // 5. enq+deq while empty acts as insert and flags deq_err
        step("enqdeq_empty", 0, 1, 1,   7,    7,  1,  0,  0,  0,  1);
        step("idle7",        0, 0, 0,   0,    7,  1,  0,  0,  0,  0);
        // Replace on a non-full queue with a smaller key: [7] -> [3]
        step("replace3",     0, 1, 1,   3,    3,  1,  0,  0,  0,  0);
        step("deq3",         0, 0, 1,   0,    0,  0,  1,  0,  0,  0);
        // Boundary keys: 0 sits behind everything, max-key ties keep order
        step("enq0",         0, 1, 0,   0,    0,  1,  0,  0,  0,  0);
        step("enq255",       0, 1, 0, 255,  255,  2,  0,  0,  0,  0);
        step("enq255b",      0, 1, 0, 255,  255,  3,  0,  0,  0,  0);
        step("enq0b",        0, 1, 0,   0,  255,  4,  0,  1,  0,  0);
        step("deq255",       0, 0, 1,   0,  255,  3,  0,  0,  0,  0);
        step("deq255b",      0, 0, 1,   0,    0,  2,  0,  0,  0,  0);
        // Replace with the maximum key: [0,0] -> [200,0]
        step("replace200",   0, 1, 1, 200,  200,  2,  0,  0,  0,  0);
        step("deq200",       0, 0, 1,   0,    0,  1,  0,  0,  0,  0);
        step("deq0",         0, 0, 1,   0,    0,  0,  1,  0,  0,  0);
        // 6. Fill to [40,30,20], then reset together with enq 99
        step("enq40",        0, 1, 0,  40,   40,  1,  0,  0,  0,  0);
        step("enq30c",       0, 1, 0,  30,   40,  2,  0,  0,  0,  0);
        step("enq20c",       0, 1, 0,  20,   40,  3,  0,  0,  0,  0);
        step("rst_enq99",    1, 1, 0,  99,    0,  0,  1,  0,  0,  0);
        step("idle_end",     0, 0, 0,   0,    0,  0,  1,  0,  0,  0);

        // Let the monitor drain the scoreboard, bounded by a cycle budget.
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
